// File: rtl/cache_access_sequencer_if.sv
// Cache-side request port of cache_access_sequencer: address/data/strobes out, stall/data back.
interface cache_access_sequencer_if #(
   parameter int unsigned address_width = 10,
   parameter int unsigned WIDTH         = 32
) ();
   logic [address_width-1:0] WordAddress;
   logic [WIDTH-1:0]         DataIn;
   logic                     mem_read;
   logic                     mem_write;
   logic                     stall;
   logic [WIDTH-1:0]         DataOut;

   modport master (
      output WordAddress, DataIn, mem_read, mem_write,
      input  stall, DataOut
   );

   modport slave (
      input  WordAddress, DataIn, mem_read, mem_write,
      output stall, DataOut
   );
endinterface

// File: rtl/cache_access_sequencer.sv
// Self-timed load/store sequencer driving a stalling cache port from a small program store.
// Optional statistics counters are built only when SEQ_STATS_EN is defined.
module cache_access_sequencer #(
   parameter int unsigned address_width = 10,
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned TIMEOUT       = 255,
   localparam int unsigned PW           = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_prog_we,
   input  logic [PW-1:0]            i_prog_idx,
   input  logic [1:0]               i_prog_op,
   input  logic [address_width-1:0] i_prog_addr,
   input  logic [WIDTH-1:0]         i_prog_data,
   input  logic                     i_start,
   cache_access_sequencer_if.master cache,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_error,
   output logic                     o_rd_valid,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic [PW-1:0]            o_rd_idx,
   output logic [15:0]              o_miss_count,
   output logic [15:0]              o_stall_cycles
);
   localparam int unsigned EW = 2 + address_width + WIDTH;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;

   logic [EW-1:0]            r_mem [DEPTH];
   logic [2:0]               r_state;
   logic [2:0]               w_state_next;
   logic [PW-1:0]            r_ptr;
   logic [1:0]               r_op;
   logic [address_width-1:0] r_addr;
   logic [WIDTH-1:0]         r_wdata;
   logic [7:0]               r_stall_cnt;
   logic                     r_error;
   logic                     r_done;
   logic                     r_rd_valid;
   logic [WIDTH-1:0]         r_rd_data;
   logic [PW-1:0]            r_rd_idx;

   logic [EW-1:0]            w_entry;
   logic [1:0]               w_entry_op;
   logic                     w_start;
   logic                     w_stall_hit;
   logic                     w_timeout;
   logic                     w_complete;
   logic                     w_last;

   assign w_entry     = r_mem[r_ptr];
   assign w_entry_op  = w_entry[EW-1 -: 2];
   assign w_start     = (r_state == S_IDLE) && i_start;
   assign w_stall_hit = (r_state == S_WAIT) && cache.stall;
   assign w_timeout   = w_stall_hit && (r_stall_cnt == 8'(TIMEOUT - 1));
   assign w_complete  = (r_state == S_WAIT) && !cache.stall;
   assign w_last      = (r_ptr == PW'(DEPTH - 1));

   // Program store is only writable while idle and is deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_prog_we && (r_state == S_IDLE)) begin
         r_mem[i_prog_idx] <= {i_prog_op, i_prog_addr, i_prog_data};
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_next = S_FETCH;
         S_FETCH: w_state_next = ((w_entry_op == OP_READ) || (w_entry_op == OP_WRITE)) ?
                                 S_ISSUE : S_DONE;
         S_ISSUE: w_state_next = S_WAIT;
         S_WAIT: begin
            if (!cache.stall)   w_state_next = w_last ? S_DONE : S_FETCH;
            else if (w_timeout) w_state_next = S_DONE;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_op        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_stall_cnt <= '0;
         r_error     <= 1'b0;
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_rd_idx    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_done     <= (r_state == S_DONE);
         r_rd_valid <= w_complete && (r_op == OP_READ);
         if (w_start) begin
            r_ptr   <= '0;
            r_error <= 1'b0;
         end
         if (r_state == S_FETCH) begin
            r_op    <= w_entry_op;
            r_addr  <= w_entry[WIDTH +: address_width];
            r_wdata <= w_entry[WIDTH-1:0];
         end
         if (r_state == S_ISSUE) r_stall_cnt <= '0;
         if (w_stall_hit) r_stall_cnt <= r_stall_cnt + 8'd1;
         if (w_timeout) r_error <= 1'b1;
         if (w_complete) begin
            if (r_op == OP_READ) begin
               r_rd_data <= cache.DataOut;
               r_rd_idx  <= r_ptr;
            end
            if (!w_last) r_ptr <= r_ptr + PW'(1);
         end
      end
   end

`ifdef SEQ_STATS_EN
   logic [15:0] r_miss_count;
   logic [15:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (reset || w_start) begin
         r_miss_count   <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_stall_hit && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
         end
         // A completion counts as a miss if its WAIT saw any stall cycle.
         if (w_complete && (r_stall_cnt != 8'd0) && (r_miss_count != 16'hFFFF)) begin
            r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   assign o_miss_count   = r_miss_count;
   assign o_stall_cycles = r_stall_cycles;
`else
   assign o_miss_count   = 16'd0;
   assign o_stall_cycles = 16'd0;
`endif

   assign cache.WordAddress = r_addr;
   assign cache.DataIn      = r_wdata;
   assign cache.mem_read    = (r_state == S_ISSUE) && (r_op == OP_READ);
   assign cache.mem_write   = (r_state == S_ISSUE) && (r_op == OP_WRITE);

   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;
   assign o_error    = r_error;
   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;
   assign o_rd_idx   = r_rd_idx;
endmodule

// File: tb/tb_cache_access_sequencer.sv
// Scoreboard bench for cache_access_sequencer with a stalling cache model.
module tb_cache_access_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset = 1'b1;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_idx = '0;
   logic [1:0]  prog_op = '0;
   logic [9:0]  prog_addr = '0;
   logic [31:0] prog_data = '0;
   logic        start = 1'b0;
   logic        busy, done, error, rd_valid;
   logic [31:0] rd_data;
   logic [3:0]  rd_idx;
   logic [15:0] miss_count, stall_cycles;

   cache_access_sequencer_if #(.address_width(10), .WIDTH(32)) cif ();

   cache_access_sequencer #(
      .address_width(10), .WIDTH(32), .DEPTH(16), .TIMEOUT(255)
   ) dut (
      .clk(clk), .reset(reset),
      .i_prog_we(prog_we), .i_prog_idx(prog_idx), .i_prog_op(prog_op),
      .i_prog_addr(prog_addr), .i_prog_data(prog_data), .i_start(start),
      .cache(cif),
      .o_busy(busy), .o_done(done), .o_error(error), .o_rd_valid(rd_valid),
      .o_rd_data(rd_data), .o_rd_idx(rd_idx),
      .o_miss_count(miss_count), .o_stall_cycles(stall_cycles)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  idx;
   } rd_t;

   rd_t         exp_rd[$];
   logic        exp_done[$];
   int          plan[$];
   logic        force_stall = 1'b0;
   logic [31:0] cmem [1024];
   int          n_tests = 0;
   int          n_fail = 0;
   int          first_strobe_cyc = -1;
   int          rdv_cyc = 0;
   int          done_cyc = 0;
   int          done_cnt = 0;
   int          rdv_cnt = 0;
   int          rd_strobes = 0;
   int          wr_strobes = 0;
   int          s_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_stats(input string name, input int miss, input int stalls);
`ifdef SEQ_STATS_EN
      check({name, "_miss"}, {16'd0, miss_count}, 32'(miss));
      check({name, "_stalls"}, {16'd0, stall_cycles}, 32'(stalls));
`else
      check({name, "_miss_tied"}, {16'd0, miss_count}, 32'd0);
      check({name, "_stalls_tied"}, {16'd0, stall_cycles}, 32'd0);
`endif
   endtask

   // Pops the scoreboard whenever the DUT presents a read result or a done pulse.
   task automatic monitor();
      rd_t e;
      logic de;
      forever begin
         @(negedge clk);
         if (cif.mem_read || cif.mem_write) begin
            check("strobe_exclusive", {31'd0, cif.mem_read & cif.mem_write}, 32'd0);
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            if (cif.mem_read) rd_strobes++;
            if (cif.mem_write) wr_strobes++;
         end
         if (rd_valid) begin
            rdv_cnt++;
            rdv_cyc = cyc;
            if (exp_rd.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_unexpected: got rd_valid idx %0d data 0x%0h, expected none",
                        rd_idx, rd_data);
            end else begin
               e = exp_rd.pop_front();
               check("rd_data", rd_data, e.data);
               check("rd_idx", {28'd0, rd_idx}, {28'd0, e.idx});
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL done_unexpected: got done pulse, expected none");
            end else begin
               de = exp_done.pop_front();
               check("done_error", {31'd0, error}, {31'd0, de});
               check("done_busy", {31'd0, busy}, 32'd0);
            end
         end
      end
   endtask

   // Cache model: each request takes the next stall count from plan (0 if empty).
   task automatic cache_model();
      int rem = 0;
      cif.stall = 1'b0;
      cif.DataOut = '0;
      forever begin
         @(negedge clk);
         if (cif.mem_write) begin
            cmem[cif.WordAddress] = cif.DataIn;
            rem = (plan.size() > 0) ? plan.pop_front() : 0;
            cif.stall = force_stall;
         end else if (cif.mem_read) begin
            cif.DataOut = cmem[cif.WordAddress];
            rem = (plan.size() > 0) ? plan.pop_front() : 0;
            cif.stall = force_stall;
         end else if (rem > 0) begin
            cif.stall = 1'b1;
            rem--;
         end else begin
            cif.stall = force_stall;
         end
      end
   endtask

   task automatic prog(input int idx, input logic [1:0] op, input logic [9:0] a,
                       input logic [31:0] d);
      @(negedge clk);
      prog_we = 1'b1;
      prog_idx = idx[3:0];
      prog_op = op;
      prog_addr = a;
      prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic do_start();
      first_strobe_cyc = -1;
      rd_strobes = 0;
      wr_strobes = 0;
      @(negedge clk);
      start = 1'b1;
      s_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c0 = done_cnt;
      int n = 0;
      while (done_cnt == c0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == c0) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse",
                  budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic push_rd(input logic [31:0] d, input logic [3:0] i);
      rd_t r;
      r.data = d;
      r.idx = i;
      exp_rd.push_back(r);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_done"}, {31'd0, done}, 32'd0);
      check({name, "_error"}, {31'd0, error}, 32'd0);
      check({name, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      check({name, "_rd_data"}, rd_data, 32'd0);
      check({name, "_rd_idx"}, {28'd0, rd_idx}, 32'd0);
      check({name, "_strobes"}, {30'd0, cif.mem_read, cif.mem_write}, 32'd0);
      check({name, "_addr"}, {22'd0, cif.WordAddress}, 32'd0);
      check({name, "_data_in"}, cif.DataIn, 32'd0);
   endtask

   initial begin
      int rdv0;
      for (int i = 0; i < 1024; i++) cmem[i] = 32'd0;
      cmem[3] = 32'hA5A5_0003;
      cmem[2] = 32'h2222_0002;
      cmem[7] = 32'h7777_0007;
      for (int i = 0; i < 16; i++) cmem[256 + i] = 32'h0000_1000 + 32'(i);

      fork
         monitor();
         cache_model();
      join_none

      // Reset state, then stall asserted while idle must be ignored.
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      check_stats("reset", 0, 0);
      reset = 1'b0;
      force_stall = 1'b1;
      repeat (6) @(negedge clk);
      check("idle_stall_busy", {31'd0, busy}, 32'd0);
      check_stats("idle_stall", 0, 0);
      force_stall = 1'b0;

      // Write hit then read with a 3-cycle miss.
      prog(0, 2'b10, 10'h001, 32'd5);
      prog(1, 2'b01, 10'h001, 32'd0);
      prog(2, 2'b00, 10'h000, 32'd0);
      plan.push_back(0);
      plan.push_back(3);
      push_rd(32'd5, 4'd1);
      exp_done.push_back(1'b0);
      do_start();
      wait_done(100);
      check_stats("wmiss_rd", 1, 3);
      check("wmiss_rd_left", 32'(exp_rd.size()), 32'd0);

      // Read hit timing.
      prog(0, 2'b01, 10'h003, 32'd0);
      prog(1, 2'b00, 10'h000, 32'd0);
      push_rd(32'hA5A5_0003, 4'd0);
      exp_done.push_back(1'b0);
      do_start();
      check("rdhit_busy_s1", {31'd0, busy}, 32'd1);
      wait_done(100);
      check("rdhit_strobe_cyc", 32'(first_strobe_cyc - s_cyc), 32'd2);
      check("rdhit_rdv_cyc", 32'(rdv_cyc - s_cyc), 32'd4);
      check_stats("rdhit", 0, 0);

      // Write hit: one write strobe, data held in WAIT.
      prog(0, 2'b10, 10'h001, 32'd15);
      prog(1, 2'b00, 10'h000, 32'd0);
      exp_done.push_back(1'b0);
      do_start();
      repeat (2) @(negedge clk);
      check("wrhit_data_held", cif.DataIn, 32'd15);
      check("wrhit_addr_held", {22'd0, cif.WordAddress}, 32'd1);
      check("wrhit_no_strobe_wait", {31'd0, cif.mem_write}, 32'd0);
      wait_done(100);
      check("wrhit_wr_strobes", 32'(wr_strobes), 32'd1);
      check("wrhit_rd_strobes", 32'(rd_strobes), 32'd0);

      // Full 16-entry program, no END; second run checks busy-time writes were ignored.
      for (int i = 0; i < 16; i++) prog(i, 2'b01, 10'(256 + i), 32'd0);
      for (int run = 0; run < 2; run++) begin
         for (int i = 0; i < 16; i++) push_rd(32'h0000_1000 + 32'(i), 4'(i));
         for (int i = 0; i < 5; i++) plan.push_back(0);
         plan.push_back(2);
         exp_done.push_back(1'b0);
         do_start();
         if (run == 0) begin
            repeat (3) @(negedge clk);
            prog_we = 1'b1;
            prog_idx = 4'd0;
            prog_op = 2'b00;
            start = 1'b1;
            @(negedge clk);
            prog_we = 1'b0;
            start = 1'b0;
         end
         wait_done(300);
         repeat (4) @(negedge clk);
         check("full_rd_strobes", 32'(rd_strobes), 32'd16);
         check("full_rd_left", 32'(exp_rd.size()), 32'd0);
         check_stats("full", 1, 2);
      end

      // Timeout with stall held high, then a fresh start clears error.
      prog(0, 2'b01, 10'h007, 32'd0);
      prog(1, 2'b00, 10'h000, 32'd0);
      force_stall = 1'b1;
      exp_done.push_back(1'b1);
      rdv0 = rdv_cnt;
      do_start();
      wait_done(400);
      check("timeout_done_cyc", 32'(done_cyc - s_cyc), 32'd259);
      check("timeout_error_sticky", {31'd0, error}, 32'd1);
      check("timeout_no_rd", 32'(rdv_cnt - rdv0), 32'd0);
      check_stats("timeout", 0, 255);
      force_stall = 1'b0;
      push_rd(32'h7777_0007, 4'd0);
      exp_done.push_back(1'b0);
      do_start();
      check("restart_error_clear", {31'd0, error}, 32'd0);
      wait_done(100);

      // Reset in the middle of a miss, then replay.
      prog(0, 2'b01, 10'h002, 32'd0);
      prog(1, 2'b00, 10'h000, 32'd0);
      plan.push_back(20);
      push_rd(32'h2222_0002, 4'd0);
      exp_done.push_back(1'b0);
      rdv0 = rdv_cnt;
      do_start();
      repeat (3) @(negedge clk);
      check("midmiss_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      exp_rd.delete();
      exp_done.delete();
      @(negedge clk);
      check_idle_outputs("midmiss_reset");
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("midmiss_no_rd", 32'(rdv_cnt - rdv0), 32'd0);
      check("midmiss_idle", {31'd0, busy}, 32'd0);
      plan.delete();
      push_rd(32'h2222_0002, 4'd0);
      exp_done.push_back(1'b0);
      do_start();
      wait_done(100);
      check("replay_rd_left", 32'(exp_rd.size()), 32'd0);
      check("replay_rd_count", 32'(rdv_cnt - rdv0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
